// File: rtl/transceiver_sched.sv
// Byte scheduler between the UART receiver and the Hamming/BPSK transmit path.
// Buffers received bytes and releases one codeword at a time onto the shared tx path.
module transceiver_sched #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PIPE_LATENCY  = 2,
  parameter int unsigned SYMBOL_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic                            rx_dv,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  output logic [DATA_WIDTH-1:0]           codec_data,
  output logic                            codec_valid,
  input  logic                            tx_active,
  input  logic                            tx_done,
  output logic                            tx_dv,
  output logic                            mod_en,
  output logic                            busy,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned SYM_W  = $clog2(SYMBOL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_LAUNCH,
    S_RUN
  } state_t;

  state_t              state, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [SYM_W-1:0]    sym_cnt, sym_cnt_d;
  logic                done_flag, done_d;
  logic                codec_valid_d, tx_dv_d, mod_en_d, busy_d;
  logic                pop, push, full;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign full = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push = rx_dv && (!full || pop);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    sym_cnt_d     = sym_cnt;
    done_d        = done_flag;
    codec_valid_d = 1'b0;
    tx_dv_d       = 1'b0;
    mod_en_d      = 1'b0;
    pop           = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_level != '0) begin
          pop           = 1'b1;
          codec_valid_d = 1'b1;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_W'(PIPE_LATENCY - 1)) begin
          if (!tx_active) begin
            tx_dv_d   = 1'b1;
            mod_en_d  = 1'b1;
            sym_cnt_d = SYM_W'(SYMBOL_CYCLES);
            done_d    = 1'b0;
            state_d   = S_LAUNCH;
          end
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_LAUNCH, S_RUN: begin
        // Counter holds the cycles left in the codeword including the current one.
        sym_cnt_d = (sym_cnt != '0) ? sym_cnt - SYM_W'(1) : '0;
        mod_en_d  = (sym_cnt > SYM_W'(1));
        done_d    = done_flag | tx_done;
        if (state == S_LAUNCH) begin
          state_d = S_RUN;
        end else if (done_flag && (sym_cnt == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM state, counters and registered control outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      sym_cnt     <= '0;
      done_flag   <= 1'b0;
      codec_valid <= 1'b0;
      tx_dv       <= 1'b0;
      mod_en      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      sym_cnt     <= sym_cnt_d;
      done_flag   <= done_d;
      codec_valid <= codec_valid_d;
      tx_dv       <= tx_dv_d;
      mod_en      <= mod_en_d;
      busy        <= busy_d;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the codec holding register.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      codec_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        codec_data <= mem[rd_ptr];
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
      if (rx_dv && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

endmodule
